cell_painter: RTL

CELL_PAINTER -- requirements
Module: cell_painter

---
 rtl/tetris_board_pkg.sv | 24 ++
 rtl/cell_painter_if.sv | 32 +++
 rtl/board_cell_origin.sv | 23 ++
 rtl/cell_painter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/tetris_board_pkg.sv
// Board geometry shared by the cell painter and the pixel-to-cell decoder.
// Also holds the painter FSM state type and bus field widths.
package tetris_board_pkg;

   localparam int X0    = 204;
   localparam int Y0    = 12;
   localparam int CELL  = 22;
   localparam int PITCH = 23;
   localparam int COLS  = 10;
   localparam int ROWS  = 20;

   localparam int COL_W = 4;
   localparam int ROW_W = 5;
   localparam int PIX_W = 10;
   localparam int CLR_W = 12;
   localparam int OFS_W = 5;

   typedef enum logic [1:0] {
      IDLE,
      PAINT,
      FINISH
   } paint_state_t;

endpackage

// File: rtl/cell_painter_if.sv
// Request and pixel-write bundle of the cell painter.
// master: requester + pixel sink side; slave: the painter itself.
interface cell_painter_if;
   import tetris_board_pkg::*;

   logic             req_valid;
   logic             req_ready;
   logic [COL_W-1:0] req_col;
   logic [ROW_W-1:0] req_row;
   logic [CLR_W-1:0] req_color;
   logic             px_valid;
   logic             px_ready;
   logic [PIX_W-1:0] px_x;
   logic [PIX_W-1:0] px_y;
   logic [CLR_W-1:0] px_color;
   logic             px_last;
   logic             done;
   logic             err;

   modport master (
      output req_valid, req_col, req_row, req_color, px_ready,
      input  req_ready, px_valid, px_x, px_y, px_color, px_last,
      input  done, err
   );

   modport slave (
      input  req_valid, req_col, req_row, req_color, px_ready,
      output req_ready, px_valid, px_x, px_y, px_color, px_last,
      output done, err
   );

endinterface

// File: rtl/board_cell_origin.sv
// Combinational (col,row) -> top-left pixel of the cell, plus range flag.
// Ports: col, row in; ox, oy, in_range out.
module board_cell_origin #(
   parameter int X0    = tetris_board_pkg::X0,
   parameter int Y0    = tetris_board_pkg::Y0,
   parameter int PITCH = tetris_board_pkg::PITCH,
   parameter int COLS  = tetris_board_pkg::COLS,
   parameter int ROWS  = tetris_board_pkg::ROWS
) (
   input  logic [3:0] col,
   input  logic [4:0] row,
   output logic [9:0] ox,
   output logic [9:0] oy,
   output logic       in_range
);

   // Even col=15/row=31 stays below 1024, so 10 bits never wrap.
   assign ox = 10'(X0) + 10'(col) * 10'(PITCH);
   assign oy = 10'(Y0) + 10'(row) * 10'(PITCH);

   assign in_range = (32'(col) < COLS) && (32'(row) < ROWS);

endmodule

// File: rtl/cell_painter.sv
// Rasterises one board cell as CELL x CELL pixel writes, x inner, y outer.
// Ports: clk, reset (sync, high); bus = request in, pixel stream out.
module cell_painter #(
   parameter int X0    = tetris_board_pkg::X0,
   parameter int Y0    = tetris_board_pkg::Y0,
   parameter int CELL  = tetris_board_pkg::CELL,
   parameter int PITCH = tetris_board_pkg::PITCH,
   parameter int COLS  = tetris_board_pkg::COLS,
   parameter int ROWS  = tetris_board_pkg::ROWS
) (
   input  logic           clk,
   input  logic           reset,
   cell_painter_if.slave  bus
);
   import tetris_board_pkg::*;

   localparam logic [4:0] CMAX = 5'(CELL - 1);

   paint_state_t state, state_nx;

   logic [3:0]  col_q;
   logic [4:0]  row_q;
   logic [11:0] clr_q;
   logic [4:0]  xo;
   logic [4:0]  yo;
   logic        err_q;

   logic [3:0]  col_s;
   logic [4:0]  row_s;
   logic [9:0]  ox;
   logic [9:0]  oy;
   logic        in_rng;
   logic        accept;
   logic        at_last;
   logic        adv;
   logic        ready_c;
   logic        valid_c;
   logic        done_c;

   // In IDLE the live request is range-checked; afterwards the
   // latched cell drives the origin for the whole raster.
   assign col_s = (state == IDLE) ? bus.req_col : col_q;
   assign row_s = (state == IDLE) ? bus.req_row : row_q;

   board_cell_origin #(
      .X0(X0), .Y0(Y0), .PITCH(PITCH), .COLS(COLS), .ROWS(ROWS)
   ) u_origin (
      .col      (col_s),
      .row      (row_s),
      .ox       (ox),
      .oy       (oy),
      .in_range (in_rng)
   );

   assign accept  = bus.req_valid && (state == IDLE);
   assign at_last = (xo == CMAX) && (yo == CMAX);
   assign adv     = (state == PAINT) && bus.px_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ready_c  = 1'b0;
      valid_c  = 1'b0;
      done_c   = 1'b0;
      unique case (state)
         IDLE: begin
            ready_c = 1'b1;
            if (accept && in_rng) state_nx = PAINT;
         end
         PAINT: begin
            valid_c = 1'b1;
            if (bus.px_ready && at_last) state_nx = FINISH;
         end
         FINISH: begin
            done_c   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_q <= '0;
         row_q <= '0;
         clr_q <= '0;
         xo    <= '0;
         yo    <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= accept && !in_rng;
         if (accept) begin
            col_q <= bus.req_col;
            row_q <= bus.req_row;
            clr_q <= bus.req_color;
            xo    <= '0;
            yo    <= '0;
         end else if (adv) begin
            if (xo == CMAX) begin
               xo <= '0;
               yo <= yo + 5'd1;
            end else begin
               xo <= xo + 5'd1;
            end
         end
      end
   end

   assign bus.req_ready = ready_c;
   assign bus.px_valid  = valid_c;
   assign bus.px_x      = valid_c ? ox + 10'(xo) : '0;
   assign bus.px_y      = valid_c ? oy + 10'(yo) : '0;
   assign bus.px_color  = valid_c ? clr_q : '0;
   assign bus.px_last   = valid_c && at_last;
   assign bus.done      = done_c;
   assign bus.err       = err_q;

endmodule
